wb_regfile_hilo: RTL and testbench

- Writeback-side storage block for the 5-stage MIPS pipeline.
- Consumes the write-back bundle registered out of the MEM/WB pipeline register: the GPR write (address/enable/data) and the HI/LO write (enable/hi/lo).
- Holds the 32-entry general-purpose register file and the HI/LO special registers.
- Provides two read ports to ID and the current HI/LO values to EX.

---
 rtl/wb_regfile_hilo.sv | 82 ++++++++
 tb/tb_wb_regfile_hilo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_hilo.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_hilo
// Purpose  : Writeback-side GPR file (2 read ports, WB write-through) and HI/LO
// Revision : 1.0
// ============================================================================
module wb_regfile_hilo #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              whilo,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam logic [ADDR_W-1:0] c_zero_addr = '0;

    logic [DATA_W-1:0] r_regs [REG_NUM];
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic              w_gpr_wr;

    assign w_gpr_wr = we && (waddr != c_zero_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_gpr_wr) begin
            r_regs[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (whilo) begin
            r_hi <= hi_i;
            r_lo <= lo_i;
        end
    end

    // Same-cycle bypass lets ID see the value WB is writing this cycle.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              re,
        input logic [ADDR_W-1:0] raddr
    );
        if (rst || !re || raddr == c_zero_addr) begin
            return '0;
        end else if (we && waddr == raddr) begin
            return wdata;
        end else begin
            return r_regs[raddr];
        end
    endfunction

    always_comb begin
        rdata1 = read_port(re1, raddr1);
        rdata2 = read_port(re2, raddr2);
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_hilo.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile_hilo
// Purpose  : Directed self-checking bench for wb_regfile_hilo
// Revision : 1.0
// ============================================================================
module tb_wb_regfile_hilo;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int pass_cnt;
    int total_cnt;

    wb_regfile_hilo #(.DATA_W(32), .ADDR_W(5), .REG_NUM(32)) dut (
        .clk(clk), .rst(rst),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .whilo(whilo), .hi_i(hi_i), .lo_i(lo_i),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;
        whilo = 1'b0; hi_i = '0; lo_i = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        we = 1'b1; waddr = 5'd5; wdata = 32'h0000_0055;
        whilo = 1'b1; hi_i = 32'h1111_1111; lo_i = 32'h2222_2222;
        tick();
        rst = 1'b1;
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        whilo = 1'b0;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd5;
        #1;
        total_cnt++;
        if (rdata1 !== 32'h0) $display("FAIL rst_rdata1 got=%h exp=%h", rdata1, 32'h0);
        else pass_cnt++;
        tick();
        rst = 1'b0; we = 1'b0;
        #1;
        total_cnt++;
        if (rdata1 !== 32'h0) $display("FAIL rst_reg5 got=%h exp=%h", rdata1, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (hi_o !== 32'h0) $display("FAIL rst_hi got=%h exp=%h", hi_o, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (lo_o !== 32'h0) $display("FAIL rst_lo got=%h exp=%h", lo_o, 32'h0);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 5'd3; wdata = 32'h1234_5678;
        tick();
        we = 1'b0;
        re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd3;
        #1;
        total_cnt++;
        if (rdata1 !== 32'h1234_5678) $display("FAIL wr_rd1 got=%h exp=%h", rdata1, 32'h1234_5678);
        else pass_cnt++;
        total_cnt++;
        if (rdata2 !== 32'h1234_5678) $display("FAIL wr_rd2 got=%h exp=%h", rdata2, 32'h1234_5678);
        else pass_cnt++;
        re1 = 1'b0;
        #1;
        total_cnt++;
        if (rdata1 !== 32'h0) $display("FAIL re1_off got=%h exp=%h", rdata1, 32'h0);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0001;
        tick();
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5_A5A5;
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
        #1;
        total_cnt++;
        if (rdata1 !== 32'hA5A5_A5A5) $display("FAIL byp_rd1 got=%h exp=%h", rdata1, 32'hA5A5_A5A5);
        else pass_cnt++;
        total_cnt++;
        if (rdata2 !== 32'hA5A5_A5A5) $display("FAIL byp_rd2 got=%h exp=%h", rdata2, 32'hA5A5_A5A5);
        else pass_cnt++;
        raddr2 = 5'd3;
        #1;
        total_cnt++;
        if (rdata2 !== 32'h1234_5678) $display("FAIL byp_other got=%h exp=%h", rdata2, 32'h1234_5678);
        else pass_cnt++;
        tick();
        we = 1'b0; raddr2 = 5'd7;
        #1;
        total_cnt++;
        if (rdata1 !== 32'hA5A5_A5A5) $display("FAIL byp_stored got=%h exp=%h", rdata1, 32'hA5A5_A5A5);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_zero();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
        #1;
        total_cnt++;
        if (rdata1 !== 32'h0) $display("FAIL zero_same got=%h exp=%h", rdata1, 32'h0);
        else pass_cnt++;
        tick();
        we = 1'b0;
        #1;
        total_cnt++;
        if (rdata1 !== 32'h0) $display("FAIL zero_after got=%h exp=%h", rdata1, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (rdata2 !== 32'h0) $display("FAIL zero_after2 got=%h exp=%h", rdata2, 32'h0);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_hilo();
        whilo = 1'b1; hi_i = 32'h0000_0001; lo_i = 32'h8000_0000;
        #1;
        total_cnt++;
        if (hi_o !== 32'h0 || lo_o !== 32'h0)
            $display("FAIL hilo_nobyp got=%h/%h exp=%h/%h", hi_o, lo_o, 32'h0, 32'h0);
        else pass_cnt++;
        tick();
        whilo = 1'b0; hi_i = 32'hFFFF_FFFF; lo_i = 32'hFFFF_FFFF;
        total_cnt++;
        if (hi_o !== 32'h1 || lo_o !== 32'h8000_0000)
            $display("FAIL hilo_wr got=%h/%h exp=%h/%h", hi_o, lo_o, 32'h1, 32'h8000_0000);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (hi_o !== 32'h1 || lo_o !== 32'h8000_0000)
            $display("FAIL hilo_hold got=%h/%h exp=%h/%h", hi_o, lo_o, 32'h1, 32'h8000_0000);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_concurrent();
        we = 1'b1; waddr = 5'd31; wdata = 32'hCAFE_F00D;
        whilo = 1'b1; hi_i = 32'd2; lo_i = 32'd3;
        tick();
        idle();
        re1 = 1'b1; raddr1 = 5'd31;
        #1;
        total_cnt++;
        if (rdata1 !== 32'hCAFE_F00D) $display("FAIL conc_reg31 got=%h exp=%h", rdata1, 32'hCAFE_F00D);
        else pass_cnt++;
        total_cnt++;
        if (hi_o !== 32'd2 || lo_o !== 32'd3)
            $display("FAIL conc_hilo got=%h/%h exp=%h/%h", hi_o, lo_o, 32'd2, 32'd3);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        vals[0] = 32'h0101_0101; vals[1] = 32'h2020_2020;
        vals[2] = 32'h3333_0000; vals[3] = 32'h0000_4444;
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; waddr = 5'(10 + i); wdata = vals[i];
            tick();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            re1 = 1'b1; raddr1 = 5'(10 + i);
            re2 = 1'b1; raddr2 = 5'(13 - i);
            #1;
            total_cnt++;
            if (rdata1 !== vals[i]) $display("FAIL b2b_rd1[%0d] got=%h exp=%h", i, rdata1, vals[i]);
            else pass_cnt++;
            total_cnt++;
            if (rdata2 !== vals[3-i]) $display("FAIL b2b_rd2[%0d] got=%h exp=%h", i, rdata2, vals[3-i]);
            else pass_cnt++;
        end
        re1 = 1'b1; raddr1 = 5'd20;
        #1;
        total_cnt++;
        if (rdata1 !== 32'h0) $display("FAIL unwritten got=%h exp=%h", rdata1, 32'h0);
        else pass_cnt++;
        idle();
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst = 1'b1;
        idle();
        test_reset();
        test_write_read();
        test_bypass();
        test_zero();
        test_hilo();
        test_concurrent();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
